video_timing_gen: RTL

- Generates 640x480@60 VGA raster timing for the video pipe.
- Issues read enables and linear addresses to the video index RAM.
- Emits hsync/vsync/active delayed by DLY cycles, so they line up with the RAM-plus-palette read latency.
- Frames start only when enabled; a frame in progress always completes before stopping.

---
 rtl/video_timing_gen_if.sv | 35 +++
 rtl/video_timing_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_timing_gen_if : raster timing bus (run control, RAM read side, |
// |                       delayed video syncs and frame pulses)          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface video_timing_gen_if #(
    parameter int AW = 19
);
    logic          vid_clk_en;
    logic          en;
    logic          run;
    logic          rd_en;
    logic [AW-1:0] rd_adr;
    logic [10:0]   h_cnt;
    logic [9:0]    v_cnt;
    logic          vid_hsync;
    logic          vid_vsync;
    logic          vid_active;
    logic          sof;
    logic          eof;

    modport master (
        input  vid_clk_en, en,
        output run, rd_en, rd_adr, h_cnt, v_cnt,
        output vid_hsync, vid_vsync, vid_active, sof, eof
    );

    modport slave (
        output vid_clk_en, en,
        input  run, rd_en, rd_adr, h_cnt, v_cnt,
        input  vid_hsync, vid_vsync, vid_active, sof, eof
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_timing_gen : VGA raster timing, index-RAM read addressing and  |
// |                    DLY-aligned hsync/vsync/active outputs            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module video_timing_gen #(
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int AW     = 19,
    parameter int DLY    = 2
) (
    input wire                vid_clk,
    input wire                vid_rst,
    video_timing_gen_if.master bus
);

    localparam int            c_H_TOT    = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int            c_V_TOT    = V_ACT + V_FP + V_SYNC + V_BP;
    localparam logic [10:0]   c_H_LAST   = 11'(c_H_TOT - 1);
    localparam logic [9:0]    c_V_LAST   = 10'(c_V_TOT - 1);
    localparam logic [10:0]   c_H_ACT    = 11'(H_ACT);
    localparam logic [9:0]    c_V_ACT    = 10'(V_ACT);
    localparam logic [10:0]   c_HS_BEG   = 11'(H_ACT + H_FP);
    localparam logic [10:0]   c_HS_END   = 11'(H_ACT + H_FP + H_SYNC);
    localparam logic [9:0]    c_VS_BEG   = 10'(V_ACT + V_FP);
    localparam logic [9:0]    c_VS_END   = 10'(V_ACT + V_FP + V_SYNC);
    localparam logic [AW-1:0] c_ADR_LAST = AW'(H_ACT * V_ACT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_nxt_state;
    logic [10:0]   r_h;
    logic [9:0]    r_v;
    logic [10:0]   w_nxt_h;
    logic [9:0]    w_nxt_v;
    logic          w_nxt_scan;
    logic          w_nxt_act;
    logic          w_nxt_hs;
    logic          w_nxt_vs;
    logic          w_nxt_sof;
    logic          w_nxt_eof;

    logic          r_run;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_adr;
    logic          r_sof;
    logic          r_eof;
    logic          r_hs_lvl;
    logic          r_vs_lvl;

    // en is only consulted when idle or on the final pixel of a frame
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_h     = r_h;
        w_nxt_v     = r_v;
        case (r_state)
            ST_IDLE: begin
                w_nxt_h = '0;
                w_nxt_v = '0;
                if (bus.en) begin
                    w_nxt_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_h == c_H_LAST) begin
                    w_nxt_h = '0;
                    if (r_v == c_V_LAST) begin
                        w_nxt_v = '0;
                        if (!bus.en) begin
                            w_nxt_state = ST_IDLE;
                        end
                    end else begin
                        w_nxt_v = r_v + 10'd1;
                    end
                end else begin
                    w_nxt_h = r_h + 11'd1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_h     = '0;
                w_nxt_v     = '0;
            end
        endcase

        w_nxt_scan = (w_nxt_state == ST_SCAN);
        w_nxt_act  = w_nxt_scan && (w_nxt_h < c_H_ACT) && (w_nxt_v < c_V_ACT);
        w_nxt_hs   = w_nxt_scan && (w_nxt_h >= c_HS_BEG) && (w_nxt_h < c_HS_END);
        w_nxt_vs   = w_nxt_scan && (w_nxt_v >= c_VS_BEG) && (w_nxt_v < c_VS_END);
        w_nxt_sof  = w_nxt_scan && (w_nxt_h == 11'd0) && (w_nxt_v == 10'd0);
        w_nxt_eof  = w_nxt_scan && (w_nxt_h == c_H_LAST) && (w_nxt_v == c_V_LAST);
    end

    always_ff @(posedge vid_clk or posedge vid_rst) begin
        if (vid_rst) begin
            r_state  <= ST_IDLE;
            r_h      <= '0;
            r_v      <= '0;
            r_run    <= 1'b0;
            r_rd_en  <= 1'b0;
            r_rd_adr <= '0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
            r_hs_lvl <= !HS_POL;
            r_vs_lvl <= !VS_POL;
        end else if (bus.vid_clk_en) begin
            r_state  <= w_nxt_state;
            r_h      <= w_nxt_h;
            r_v      <= w_nxt_v;
            r_run    <= w_nxt_scan;
            r_rd_en  <= w_nxt_act;
            r_sof    <= w_nxt_sof;
            r_eof    <= w_nxt_eof;
            r_hs_lvl <= w_nxt_hs ? HS_POL : !HS_POL;
            r_vs_lvl <= w_nxt_vs ? VS_POL : !VS_POL;
            // Address parks on the last pixel of the frame until the next sof
            if (w_nxt_sof) begin
                r_rd_adr <= '0;
            end else if (r_rd_en && (r_rd_adr != c_ADR_LAST)) begin
                r_rd_adr <= r_rd_adr + AW'(1);
            end
        end
    end

    if (DLY == 0) begin : g_dly_none
        assign bus.vid_active = r_rd_en;
        assign bus.vid_hsync  = r_hs_lvl;
        assign bus.vid_vsync  = r_vs_lvl;
    end else begin : g_dly_line
        // Stage bits: [2] vsync level, [1] hsync level, [0] active
        logic [2:0] r_dly [DLY];

        always_ff @(posedge vid_clk or posedge vid_rst) begin
            if (vid_rst) begin
                for (int i = 0; i < DLY; i++) begin
                    r_dly[i] <= {!VS_POL, !HS_POL, 1'b0};
                end
            end else if (bus.vid_clk_en) begin
                r_dly[0] <= {r_vs_lvl, r_hs_lvl, r_rd_en};
                for (int i = 1; i < DLY; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end

        assign bus.vid_active = r_dly[DLY-1][0];
        assign bus.vid_hsync  = r_dly[DLY-1][1];
        assign bus.vid_vsync  = r_dly[DLY-1][2];
    end

    assign bus.run    = r_run;
    assign bus.rd_en  = r_rd_en;
    assign bus.rd_adr = r_rd_adr;
    assign bus.h_cnt  = r_h;
    assign bus.v_cnt  = r_v;
    assign bus.sof    = r_sof;
    assign bus.eof    = r_eof;

endmodule
`default_nettype wire
